accum_divider: RTL and testbench



---
 rtl/accum_div_pkg.sv | 13 +
 rtl/accum_divider_if.sv | 19 +
 rtl/accum_divider_div_step.sv | 24 ++
 rtl/accum_divider.sv | 120 ++++++++++++
 tb/tb_accum_divider.sv | 124 ++++++++++++
 5 files changed

// File: rtl/accum_div_pkg.sv
// accum_divider shared types and default widths.
package accum_div_pkg;
  localparam int DIV_DW = 17;
  localparam int DIV_VW = 16;
  localparam int DIV_CW = $clog2(DIV_DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } div_state_e;
endpackage

// File: rtl/accum_divider_if.sv
// accum_divider request/result bundle. master = requester, slave = divider.
interface accum_divider_if #(
  parameter int DW = 17,
  parameter int VW = 16
);
  logic          Run;
  logic [DW-1:0] Dividend;
  logic [VW-1:0] Divisor;
  logic [DW-1:0] Quotient;
  logic [VW-1:0] Remainder;
  logic          Busy;
  logic          Done;
  logic          DivByZero;

  modport master (output Run, Dividend, Divisor,
                  input  Quotient, Remainder, Busy, Done, DivByZero);
  modport slave  (input  Run, Dividend, Divisor,
                  output Quotient, Remainder, Busy, Done, DivByZero);
endinterface

// File: rtl/accum_divider_div_step.sv
// div_step: one restoring shift-subtract iteration.
// The restored remainder is always < D, so VW bits hold it exactly.
module div_step
  import accum_div_pkg::*;
#(
  parameter int VW = DIV_VW
) (
  input  logic [VW-1:0] r_in,
  input  logic          bit_in,
  input  logic [VW-1:0] d,
  output logic [VW-1:0] r_out,
  output logic          q_bit
);
  logic [VW:0] t;
  logic [VW:0] diff;

  // shift in next dividend bit, subtract when it fits
  always_comb begin
    t     = {r_in, bit_in};
    diff  = t - {1'b0, d};
    q_bit = (t >= {1'b0, d});
    r_out = q_bit ? diff[VW-1:0] : t[VW-1:0];
  end
endmodule

// File: rtl/accum_divider.sv
// accum_divider: sequential restoring divider, DW iterations per start.
// Optional zero-divisor fast path: ACCUM_DIV_ZERO_CHECK_EN.
module accum_divider
  import accum_div_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input logic           Clk,
  input logic           Reset,
  accum_divider_if.slave bus
);
  localparam int CW = $clog2(DW);

  div_state_e    state, state_nxt;
  logic          run_q, start, zero_div;
  logic [DW-1:0] q_r, q_nxt;
  logic [VW-1:0] d_r, r_r, r_nxt;
  logic [CW-1:0] cnt;
  logic          q_bit;
  logic [DW-1:0] quo_q;
  logic [VW-1:0] rem_q;
  logic          done_q;

  assign start = bus.Run & ~run_q;

`ifdef ACCUM_DIV_ZERO_CHECK_EN
  assign zero_div = (bus.Divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  div_step #(.VW(VW)) u_step (
    .r_in  (r_r),
    .bit_in(q_r[DW-1]),
    .d     (d_r),
    .r_out (r_nxt),
    .q_bit (q_bit)
  );

  assign q_nxt = {q_r[DW-2:0], q_bit};

  // state register
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = zero_div ? DONE : CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = bus.Run ? HOLD : IDLE;
      HOLD:    if (!bus.Run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // operand capture, iteration registers and result registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      run_q  <= 1'b1;  // Run held through reset must not start a division
      q_r    <= '0;
      d_r    <= '0;
      r_r    <= '0;
      cnt    <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      done_q <= 1'b0;
    end else begin
      run_q  <= bus.Run;
      done_q <= (state_nxt == DONE);
      case (state)
        IDLE: if (start) begin
          q_r <= bus.Dividend;
          d_r <= bus.Divisor;
          r_r <= '0;
          cnt <= CW'(DW - 1);
`ifdef ACCUM_DIV_ZERO_CHECK_EN
          if (zero_div) begin
            quo_q <= '1;
            rem_q <= bus.Dividend[VW-1:0];
          end
`endif
        end
        CALC: begin
          q_r <= q_nxt;
          r_r <= r_nxt;
          if (cnt == '0) begin
            quo_q <= q_nxt;
            rem_q <= r_nxt;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ACCUM_DIV_ZERO_CHECK_EN
  logic dbz_q;
  // divide-by-zero flag updates with the results
  always_ff @(posedge Clk) begin
    if (Reset)                                    dbz_q <= 1'b0;
    else if (state == IDLE && start && zero_div)  dbz_q <= 1'b1;
    else if (state == CALC && cnt == '0)          dbz_q <= 1'b0;
  end
  assign bus.DivByZero = dbz_q;
`else
  assign bus.DivByZero = 1'b0;
`endif

  assign bus.Quotient  = quo_q;
  assign bus.Remainder = rem_q;
  assign bus.Done      = done_q;
  assign bus.Busy      = (state == CALC);
endmodule

// File: tb/tb_accum_divider.sv
// tb_accum_divider: directed + random checks for accum_divider.
// Honours ACCUM_DIV_ZERO_CHECK_EN for the zero-divisor expectations.
module tb_accum_divider;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  accum_divider_if #(.DW(17), .VW(16)) bus ();

  accum_divider #(.DW(17), .VW(16)) dut (
    .Clk  (clk),
    .Reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Start at edge k, hold Run for hold cycles, then release.
  // lat = number of edges after k at which Done is first seen (0 = right after k).
  task automatic run_div(input string tag, input logic [16:0] dvd, input logic [15:0] dvs,
                         input logic [16:0] eq, input logic [15:0] er, input logic edbz,
                         input int elat, input int ebusy, input int hold, input int chg_at);
    int lat, nd, nb;
    bus.Dividend = dvd;
    bus.Divisor  = dvs;
    bus.Run      = 1'b1;
    tick();  // edge k
    lat = -1; nd = 0; nb = 0;
    if (bus.Done) begin nd++; lat = 0; end
    for (int c = 1; c <= hold; c++) begin
      if (bus.Busy) nb++;
      if (c == chg_at) begin bus.Dividend = 17'd50; bus.Divisor = 16'd3; end
      tick();
      if (bus.Done) begin nd++; if (lat < 0) lat = c; end
    end
    chk({tag, ".lat"},   64'(lat), 64'(elat));
    chk({tag, ".ndone"}, 64'(nd),  64'd1);
    chk({tag, ".busy"},  64'(nb),  64'(ebusy));
    chk({tag, ".quo"},   64'(bus.Quotient),  64'(eq));
    chk({tag, ".rem"},   64'(bus.Remainder), 64'(er));
    chk({tag, ".dbz"},   64'(bus.DivByZero), 64'(edbz));
    bus.Run = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    logic [16:0] dvd;
    logic [15:0] dvs;
    int nd, nb;

    reset = 1'b1;
    bus.Run = 1'b0; bus.Dividend = '0; bus.Divisor = '0;
    repeat (3) tick();
    chk("rst.quo",  64'(bus.Quotient),  64'd0);
    chk("rst.rem",  64'(bus.Remainder), 64'd0);
    chk("rst.busy", 64'(bus.Busy),      64'd0);
    chk("rst.done", 64'(bus.Done),      64'd0);
    chk("rst.dbz",  64'(bus.DivByZero), 64'd0);
    reset = 1'b0;
    repeat (2) tick();

    run_div("d100_7",  17'd100,     16'd7, 17'd14,      16'd2, 1'b0, 17, 17, 19, 0);
    run_div("dmax_1",  17'h1FFFF,   16'd1, 17'h1FFFF,   16'd0, 1'b0, 17, 17, 19, 0);
    run_div("d5_9",    17'd5,       16'd9, 17'd0,       16'd5, 1'b0, 17, 17, 19, 0);
`ifdef ACCUM_DIV_ZERO_CHECK_EN
    // Done visible in the cycle ending at edge k+1
    run_div("dzero",   17'h00123,   16'd0, 17'h1FFFF, 16'h0123, 1'b1, 0, 0, 19, 0);
`else
    run_div("dzero",   17'h00123,   16'd0, 17'h1FFFF, 16'h0123, 1'b0, 17, 17, 19, 0);
`endif
    run_div("hold40",  17'd100,     16'd7, 17'd14,      16'd2, 1'b0, 17, 17, 40, 0);
    run_div("midchg",  17'd100,     16'd7, 17'd14,      16'd2, 1'b0, 17, 17, 19, 5);
    run_div("d65535",  17'd65535,   16'd256, 17'd255,   16'd255, 1'b0, 17, 17, 19, 0);

    // reset at edge k+5 with Run held
    bus.Dividend = 17'd100; bus.Divisor = 16'd7; bus.Run = 1'b1;
    tick();                 // edge k
    repeat (4) tick();      // after edge k+4
    reset = 1'b1;
    tick();                 // edge k+5
    chk("mrst.quo",  64'(bus.Quotient),  64'd0);
    chk("mrst.rem",  64'(bus.Remainder), 64'd0);
    chk("mrst.busy", 64'(bus.Busy),      64'd0);
    chk("mrst.done", 64'(bus.Done),      64'd0);
    chk("mrst.dbz",  64'(bus.DivByZero), 64'd0);
    reset = 1'b0;
    nd = 0; nb = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (bus.Done) nd++;
      if (bus.Busy) nb++;
    end
    chk("mrst.nodone", 64'(nd), 64'd0);
    chk("mrst.nobusy", 64'(nb), 64'd0);
    bus.Run = 1'b0;
    repeat (2) tick();
    run_div("post_rst", 17'd100, 16'd7, 17'd14, 16'd2, 1'b0, 17, 17, 19, 0);

    // random nonzero-divisor runs
    for (int i = 0; i < 1000; i++) begin
      dvd = 17'($urandom_range(0, 17'h1FFFF));
      dvs = 16'($urandom_range(1, 16'hFFFF));
      run_div("rnd", dvd, dvs, 17'(dvd / 17'(dvs)), 16'(dvd % 17'(dvs)), 1'b0, 17, 17, 17, 0);
      chk("rnd.inv", 64'(bus.Quotient) * 64'(dvs) + 64'(bus.Remainder), 64'(dvd));
      chk("rnd.rlt", 64'(bus.Remainder < dvs), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
